// File: rtl/sharpmz_pkg.sv
// Shared constants for the Sharp MZ HPS ioctl responder: FSM state codes and
// byte-lane positions inside the 16-bit ioctl data word.
package sharpmz_pkg;

    localparam logic [2:0] ST_IDLE  = 3'd0;
    localparam logic [2:0] ST_WR_LO = 3'd1;
    localparam logic [2:0] ST_WR_HI = 3'd2;
    localparam logic [2:0] ST_RD_LO = 3'd3;
    localparam logic [2:0] ST_RD_HI = 3'd4;

    localparam int LANE_W  = 8;
    localparam int LANE_LO = 0;
    localparam int LANE_HI = 8;

endpackage

// File: rtl/hps_ioctl_responder.sv
// Bridges 16-bit HPS ioctl download/upload words onto a byte-wide emulator
// memory port, splitting each word into a low-byte then high-byte access.
module hps_ioctl_responder
    import sharpmz_pkg::*;
#(
    parameter logic [7:0] INDEX  = 8'h00,
    parameter int         ADDR_W = 25
) (
    input  logic              clk_sys,
    input  logic              reset,
    input  logic              ioctl_download,
    input  logic              ioctl_upload,
    input  logic [7:0]        ioctl_index,
    input  logic              ioctl_wr,
    input  logic              ioctl_rd,
    input  logic [ADDR_W-1:0] ioctl_addr,
    input  logic [15:0]       ioctl_dout,
    output logic [15:0]       ioctl_din,
    output logic              ioctl_wait,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [7:0]        mem_wdata,
    output logic              mem_we,
    output logic              mem_rd,
    input  logic [7:0]        mem_rdata,
    input  logic              mem_ack,
    output logic              xfer_done,
    output logic              proto_err
);

    logic [2:0]        state;
    logic [2:0]        state_nx;
    logic [ADDR_W-2:0] base;
    logic [7:0]        wdata_hi;

    logic dl_q;
    logic ul_q;
    logic done_pending;

    logic index_hit;
    logic take_wr;
    logic take_rd;
    logic any_strobe;
    logic flag_rise;
    logic xfer_end;
    logic unused_addr_lsb;

    assign unused_addr_lsb = ioctl_addr[0];

    assign index_hit  = (ioctl_index == INDEX);
    assign take_wr    = ioctl_wr & ioctl_download & index_hit;
    assign take_rd    = ioctl_rd & ioctl_upload & index_hit & ~take_wr;
    assign any_strobe = ioctl_wr | ioctl_rd;
    assign flag_rise  = (ioctl_download & ~dl_q) | (ioctl_upload & ~ul_q);
    assign xfer_end   = index_hit & ((dl_q & ~ioctl_download) | (ul_q & ~ioctl_upload));

    always_comb begin
        state_nx = state;
        case (state)
            ST_IDLE: begin
                if (take_wr) begin
                    state_nx = ST_WR_LO;
                end else if (take_rd) begin
                    state_nx = ST_RD_LO;
                end
            end
            ST_WR_LO: if (mem_ack) state_nx = ST_WR_HI;
            ST_WR_HI: if (mem_ack) state_nx = ST_IDLE;
            ST_RD_LO: if (mem_ack) state_nx = ST_RD_HI;
            ST_RD_HI: if (mem_ack) state_nx = ST_IDLE;
            default:  state_nx = ST_IDLE;
        endcase
    end

    // The base is kept as a word address, so the high-byte address is just
    // {base,1} and can never carry out of the address width.
    always_ff @(posedge clk_sys or posedge reset) begin
        if (reset) begin
            state      <= ST_IDLE;
            ioctl_wait <= 1'b0;
            base       <= '0;
            wdata_hi   <= '0;
            ioctl_din  <= '0;
            mem_addr   <= '0;
            mem_wdata  <= '0;
            mem_we     <= 1'b0;
            mem_rd     <= 1'b0;
        end else begin
            state      <= state_nx;
            ioctl_wait <= (state_nx != ST_IDLE);
            case (state)
                ST_IDLE: begin
                    if (take_wr) begin
                        base      <= ioctl_addr[ADDR_W-1:1];
                        wdata_hi  <= ioctl_dout[LANE_HI +: LANE_W];
                        mem_addr  <= {ioctl_addr[ADDR_W-1:1], 1'b0};
                        mem_wdata <= ioctl_dout[LANE_LO +: LANE_W];
                        mem_we    <= 1'b1;
                    end else if (take_rd) begin
                        base     <= ioctl_addr[ADDR_W-1:1];
                        mem_addr <= {ioctl_addr[ADDR_W-1:1], 1'b0};
                        mem_rd   <= 1'b1;
                    end
                end
                ST_WR_LO: begin
                    if (mem_ack) begin
                        mem_addr  <= {base, 1'b1};
                        mem_wdata <= wdata_hi;
                    end
                end
                ST_WR_HI: begin
                    if (mem_ack) mem_we <= 1'b0;
                end
                ST_RD_LO: begin
                    if (mem_ack) begin
                        ioctl_din[LANE_LO +: LANE_W] <= mem_rdata;
                        mem_addr                     <= {base, 1'b1};
                    end
                end
                ST_RD_HI: begin
                    if (mem_ack) begin
                        ioctl_din[LANE_HI +: LANE_W] <= mem_rdata;
                        mem_rd                       <= 1'b0;
                    end
                end
                default: begin
                    mem_we <= 1'b0;
                    mem_rd <= 1'b0;
                end
            endcase
        end
    end

    // A transfer that ends while a byte pair is still in flight is remembered
    // and reported once the responder has gone idle again.
    always_ff @(posedge clk_sys or posedge reset) begin
        if (reset) begin
            dl_q         <= 1'b0;
            ul_q         <= 1'b0;
            done_pending <= 1'b0;
            xfer_done    <= 1'b0;
            proto_err    <= 1'b0;
        end else begin
            dl_q      <= ioctl_download;
            ul_q      <= ioctl_upload;
            xfer_done <= 1'b0;

            if (flag_rise) proto_err <= 1'b0;
            if (any_strobe && state != ST_IDLE) proto_err <= 1'b1;

            if (state == ST_IDLE && (xfer_end || done_pending)) begin
                xfer_done    <= 1'b1;
                done_pending <= 1'b0;
            end else if (xfer_end) begin
                done_pending <= 1'b1;
            end
        end
    end

endmodule

// File: tb/tb_hps_ioctl_responder.sv
// Self-checking bench for hps_ioctl_responder: directed scenarios plus random
// transfers checked against a word-level memory model.
module tb_hps_ioctl_responder;

    localparam int         ADDR_W = 25;
    localparam logic [7:0] INDEX  = 8'h00;

    logic              clk_sys = 1'b0;
    logic              reset;
    logic              ioctl_download;
    logic              ioctl_upload;
    logic [7:0]        ioctl_index;
    logic              ioctl_wr;
    logic              ioctl_rd;
    logic [ADDR_W-1:0] ioctl_addr;
    logic [15:0]       ioctl_dout;
    logic [15:0]       ioctl_din;
    logic              ioctl_wait;
    logic [ADDR_W-1:0] mem_addr;
    logic [7:0]        mem_wdata;
    logic              mem_we;
    logic              mem_rd;
    logic [7:0]        mem_rdata = 8'h00;
    logic              mem_ack = 1'b0;
    logic              xfer_done;
    logic              proto_err;

    int total = 0;
    int bad   = 0;

    always #5 clk_sys = ~clk_sys;

    hps_ioctl_responder #(.INDEX(INDEX), .ADDR_W(ADDR_W)) dut (
        .clk_sys(clk_sys), .reset(reset),
        .ioctl_download(ioctl_download), .ioctl_upload(ioctl_upload),
        .ioctl_index(ioctl_index), .ioctl_wr(ioctl_wr), .ioctl_rd(ioctl_rd),
        .ioctl_addr(ioctl_addr), .ioctl_dout(ioctl_dout), .ioctl_din(ioctl_din),
        .ioctl_wait(ioctl_wait), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
        .mem_we(mem_we), .mem_rd(mem_rd), .mem_rdata(mem_rdata),
        .mem_ack(mem_ack), .xfer_done(xfer_done), .proto_err(proto_err)
    );

    // Emulator memory behind the DUT, and the bench's own expectation of it.
    logic [7:0]        mem_store [logic [ADDR_W-1:0]];
    logic [7:0]        ref_mem   [logic [ADDR_W-1:0]];
    logic [ADDR_W+7:0] wr_log[$];
    logic [15:0]       model_din = 16'h0000;
    int                ack_delay = 0;
    int                ack_cnt   = 0;
    int                viol      = 0;
    bit                din_mon_en = 1'b0;
    logic              prev_wait = 1'b0;
    logic [15:0]       prev_din  = 16'h0000;

    function automatic logic [7:0] init_byte(input logic [ADDR_W-1:0] a);
        return a[7:0] ^ 8'h5A;
    endfunction

    function automatic logic [7:0] store_read(input logic [ADDR_W-1:0] a);
        if (mem_store.exists(a)) return mem_store[a];
        return init_byte(a);
    endfunction

    function automatic logic [7:0] ref_read(input logic [ADDR_W-1:0] a);
        if (ref_mem.exists(a)) return ref_mem[a];
        return init_byte(a);
    endfunction

    // Memory responder: acknowledges each request after ack_delay idle cycles.
    always @(negedge clk_sys) begin
        mem_ack = 1'b0;
        if (reset || !(mem_we || mem_rd)) begin
            ack_cnt = 0;
        end else if (ack_cnt >= ack_delay) begin
            mem_ack = 1'b1;
            ack_cnt = 0;
            if (mem_rd) mem_rdata = store_read(mem_addr);
            if (mem_we) begin
                mem_store[mem_addr] = mem_wdata;
                wr_log.push_back({mem_addr, mem_wdata});
            end
        end else begin
            ack_cnt++;
        end
    end

    always @(negedge clk_sys) begin
        if (mem_we && mem_rd) viol++;
        if (din_mon_en && !ioctl_wait && !prev_wait && ioctl_din !== prev_din) viol++;
        prev_wait = ioctl_wait;
        prev_din  = ioctl_din;
    end

    task automatic strobe(input bit is_wr, input logic [7:0] idx,
                          input logic [ADDR_W-1:0] a, input logic [15:0] d);
        @(negedge clk_sys);
        ioctl_index = idx;
        ioctl_addr  = a;
        ioctl_dout  = d;
        ioctl_wr    = is_wr;
        ioctl_rd    = ~is_wr;
        @(negedge clk_sys);
        ioctl_wr = 1'b0;
        ioctl_rd = 1'b0;
    endtask

    task automatic wait_idle(input int budget, output int busy, output int rd_cyc, output bit timed_out);
        busy = 0;
        rd_cyc = 0;
        timed_out = 1'b0;
        while (ioctl_wait) begin
            if (mem_rd) rd_cyc++;
            busy++;
            if (busy > budget) begin
                timed_out = 1'b1;
                break;
            end
            @(negedge clk_sys);
        end
    endtask

    task automatic test_reset();
        reset = 1'b1;
        ioctl_download = 0; ioctl_upload = 0; ioctl_index = INDEX;
        ioctl_wr = 0; ioctl_rd = 0; ioctl_addr = '0; ioctl_dout = '0;
        repeat (3) @(negedge clk_sys);
        total++;
        if ({ioctl_wait, mem_we, mem_rd, xfer_done, proto_err} !== 5'b0) begin
            bad++;
            $display("[TB] FAIL reset_flags: got %b want 00000", {ioctl_wait, mem_we, mem_rd, xfer_done, proto_err});
        end
        total++;
        if (ioctl_din !== 16'h0000 || mem_addr !== '0 || mem_wdata !== 8'h00) begin
            bad++;
            $display("[TB] FAIL reset_data: got din=%h addr=%h wdata=%h want all 0", ioctl_din, mem_addr, mem_wdata);
        end
        reset = 1'b0;
        repeat (2) @(negedge clk_sys);
        din_mon_en = 1'b1;
    endtask

    task automatic test_download();
        int n0, busy, rdc;
        bit to;
        ack_delay = 0;
        @(negedge clk_sys);
        ioctl_index = INDEX;
        ioctl_download = 1'b1;
        n0 = wr_log.size();
        strobe(1'b1, INDEX, 25'h000100, 16'hBEEF);
        wait_idle(20, busy, rdc, to);
        ref_mem[25'h100] = 8'hEF;
        ref_mem[25'h101] = 8'hBE;
        total++;
        if (to || busy < 2) begin
            bad++;
            $display("[TB] FAIL dl_wait: got busy=%0d timeout=%0d want >=2 and no timeout", busy, to);
        end
        total++;
        if (wr_log.size() != n0 + 2) begin
            bad++;
            $display("[TB] FAIL dl_count: got %0d writes want 2", wr_log.size() - n0);
        end else begin
            total++;
            if (wr_log[n0] !== {25'h100, 8'hEF} || wr_log[n0+1] !== {25'h101, 8'hBE}) begin
                bad++;
                $display("[TB] FAIL dl_bytes: got %h,%h want 100:ef,101:be", wr_log[n0], wr_log[n0+1]);
            end
        end
        ioctl_download = 1'b0;
        @(negedge clk_sys);
        total++;
        if (xfer_done !== 1'b1) begin
            bad++;
            $display("[TB] FAIL dl_done_pulse: got %b want 1", xfer_done);
        end
        @(negedge clk_sys);
        total++;
        if (xfer_done !== 1'b0) begin
            bad++;
            $display("[TB] FAIL dl_done_width: got %b want 0", xfer_done);
        end
    endtask

    task automatic test_upload();
        int busy, rdc;
        bit to;
        mem_store[25'h200] = 8'h34; mem_store[25'h201] = 8'h12;
        ref_mem[25'h200]   = 8'h34; ref_mem[25'h201]   = 8'h12;
        ack_delay = 3;
        @(negedge clk_sys);
        ioctl_upload = 1'b1;
        strobe(1'b0, INDEX, 25'h000200, 16'h0000);
        wait_idle(40, busy, rdc, to);
        model_din = {ref_read(25'h201), ref_read(25'h200)};
        total++;
        if (to || ioctl_din !== model_din) begin
            bad++;
            $display("[TB] FAIL ul_data: got %h timeout=%0d want %h", ioctl_din, to, model_din);
        end
        total++;
        if (rdc != 2 * (ack_delay + 1)) begin
            bad++;
            $display("[TB] FAIL ul_rd_held: got %0d cycles want %0d", rdc, 2 * (ack_delay + 1));
        end
        ioctl_upload = 1'b0;
        ack_delay = 0;
        repeat (2) @(negedge clk_sys);
    endtask

    task automatic test_index_filter();
        int n0;
        bit seen;
        @(negedge clk_sys);
        ioctl_download = 1'b1;
        n0 = wr_log.size();
        seen = 1'b0;
        strobe(1'b1, 8'h01, 25'h000300, 16'h1111);
        for (int k = 0; k < 4; k++) begin
            if (ioctl_wait || mem_we) seen = 1'b1;
            @(negedge clk_sys);
        end
        total++;
        if (seen || wr_log.size() != n0) begin
            bad++;
            $display("[TB] FAIL idx_filter: got busy=%b writes=%0d want 0/0", seen, wr_log.size() - n0);
        end
        ioctl_download = 1'b0;
        seen = 1'b0;
        for (int k = 0; k < 3; k++) begin
            @(negedge clk_sys);
            if (xfer_done) seen = 1'b1;
        end
        total++;
        if (seen) begin
            bad++;
            $display("[TB] FAIL idx_no_done: got xfer_done=1 want 0");
        end
        strobe(1'b1, INDEX, 25'h000300, 16'h2222);
        total++;
        if (ioctl_wait !== 1'b0 || wr_log.size() != n0) begin
            bad++;
            $display("[TB] FAIL no_flag: got wait=%b writes=%0d want 0/0", ioctl_wait, wr_log.size() - n0);
        end
    endtask

    task automatic test_proto_err();
        int n0, busy, rdc;
        bit to, found;
        ack_delay = 3;
        @(negedge clk_sys);
        ioctl_index = INDEX;
        ioctl_download = 1'b1;
        n0 = wr_log.size();
        strobe(1'b1, INDEX, 25'h000400, 16'hC3A5);
        found = 1'b0;
        for (int k = 0; k < 20; k++) begin
            if (mem_we && mem_addr === 25'h401) begin
                found = 1'b1;
                break;
            end
            @(negedge clk_sys);
        end
        total++;
        if (!found) begin
            bad++;
            $display("[TB] FAIL pe_reach_hi: got no high-byte write want one within 20 cycles");
        end
        strobe(1'b1, INDEX, 25'h000500, 16'h7777);
        wait_idle(40, busy, rdc, to);
        ref_mem[25'h400] = 8'hA5;
        ref_mem[25'h401] = 8'hC3;
        total++;
        if (to || proto_err !== 1'b1) begin
            bad++;
            $display("[TB] FAIL pe_set: got proto_err=%b timeout=%0d want 1", proto_err, to);
        end
        total++;
        if (wr_log.size() != n0 + 2 || wr_log[n0] !== {25'h400, 8'hA5} || wr_log[n0+1] !== {25'h401, 8'hC3}) begin
            bad++;
            $display("[TB] FAIL pe_single_word: got %0d writes want exactly 400:a5,401:c3", wr_log.size() - n0);
        end
        ioctl_download = 1'b0;
        repeat (2) @(negedge clk_sys);
        total++;
        if (proto_err !== 1'b1) begin
            bad++;
            $display("[TB] FAIL pe_sticky: got %b want 1", proto_err);
        end
        ioctl_download = 1'b1;
        @(negedge clk_sys);
        total++;
        if (proto_err !== 1'b0) begin
            bad++;
            $display("[TB] FAIL pe_clear: got %b want 0", proto_err);
        end
        ioctl_download = 1'b0;
        ack_delay = 0;
        repeat (2) @(negedge clk_sys);
    endtask

    task automatic test_wrap();
        int n0, busy, rdc;
        bit to;
        @(negedge clk_sys);
        ioctl_download = 1'b1;
        n0 = wr_log.size();
        strobe(1'b1, INDEX, 25'h1FFFFFF, 16'hA55A);
        wait_idle(20, busy, rdc, to);
        ref_mem[25'h1FFFFFE] = 8'h5A;
        ref_mem[25'h1FFFFFF] = 8'hA5;
        total++;
        if (to || wr_log.size() != n0 + 2 ||
            wr_log[n0] !== {25'h1FFFFFE, 8'h5A} || wr_log[n0+1] !== {25'h1FFFFFF, 8'hA5}) begin
            bad++;
            $display("[TB] FAIL wrap_top: got %0d writes first=%h want 1fffffe:5a,1ffffff:a5", wr_log.size() - n0, wr_log[n0]);
        end
        ioctl_download = 1'b0;
        repeat (2) @(negedge clk_sys);
    endtask

    task automatic test_reset_mid();
        int busy, rdc;
        bit to;
        ack_delay = 5;
        @(negedge clk_sys);
        ioctl_upload = 1'b1;
        strobe(1'b0, INDEX, 25'h000200, 16'h0000);
        total++;
        if (mem_rd !== 1'b1) begin
            bad++;
            $display("[TB] FAIL rm_in_rd_lo: got mem_rd=%b want 1", mem_rd);
        end
        din_mon_en = 1'b0;
        #2 reset = 1'b1;
        #1;
        model_din = 16'h0000;
        total++;
        if (mem_rd !== 1'b0 || ioctl_wait !== 1'b0 || ioctl_din !== model_din || mem_addr !== '0) begin
            bad++;
            $display("[TB] FAIL rm_async: got rd=%b wait=%b din=%h addr=%h want 0/0/0/0", mem_rd, ioctl_wait, ioctl_din, mem_addr);
        end
        @(negedge clk_sys);
        reset = 1'b0;
        ack_delay = 0;
        strobe(1'b0, INDEX, 25'h000200, 16'h0000);
        wait_idle(20, busy, rdc, to);
        model_din = {ref_read(25'h201), ref_read(25'h200)};
        total++;
        if (to || ioctl_din !== model_din) begin
            bad++;
            $display("[TB] FAIL rm_next_rd: got %h want %h", ioctl_din, model_din);
        end
        ioctl_upload = 1'b0;
        repeat (2) @(negedge clk_sys);
        din_mon_en = 1'b1;
    endtask

    task automatic test_random();
        int n0, busy, rdc;
        bit to, is_wr, flag, accept, ok;
        logic [7:0]        idx;
        logic [ADDR_W-1:0] a, lo_a, hi_a;
        logic [15:0]       d;
        for (int i = 0; i < 40; i++) begin
            is_wr = 1'($urandom_range(0, 1));
            flag  = ($urandom_range(0, 7) != 0);
            idx   = ($urandom_range(0, 7) != 0) ? INDEX : 8'($urandom_range(1, 255));
            a     = ($urandom_range(0, 9) == 0) ? ADDR_W'($urandom) : ADDR_W'($urandom_range(0, 31));
            d     = 16'($urandom);
            lo_a  = {a[ADDR_W-1:1], 1'b0};
            hi_a  = lo_a + 1'b1;
            accept = flag && (idx == INDEX);
            ack_delay = $urandom_range(0, 2);
            @(negedge clk_sys);
            ioctl_download = is_wr & flag;
            ioctl_upload   = ~is_wr & flag;
            n0 = wr_log.size();
            strobe(is_wr, idx, a, d);
            total++;
            if (ioctl_wait !== accept) begin
                bad++;
                $display("[TB] FAIL rnd_wait[%0d]: got %b want %b", i, ioctl_wait, accept);
            end
            wait_idle(40, busy, rdc, to);
            if (is_wr) begin
                ok = !to && (wr_log.size() == n0 + (accept ? 2 : 0));
                if (ok && accept)
                    ok = (wr_log[n0] === {lo_a, d[7:0]}) && (wr_log[n0+1] === {hi_a, d[15:8]});
                if (accept) begin
                    ref_mem[lo_a] = d[7:0];
                    ref_mem[hi_a] = d[15:8];
                end
                total++;
                if (!ok) begin
                    bad++;
                    $display("[TB] FAIL rnd_write[%0d]: got %0d writes at %h want %0d of %h", i, wr_log.size() - n0, lo_a, accept ? 2 : 0, d);
                end
            end else begin
                if (accept) model_din = {ref_read(hi_a), ref_read(lo_a)};
                total++;
                if (to || ioctl_din !== model_din) begin
                    bad++;
                    $display("[TB] FAIL rnd_read[%0d]: got %h want %h", i, ioctl_din, model_din);
                end
            end
        end
        ioctl_download = 1'b0;
        ioctl_upload   = 1'b0;
        repeat (3) @(negedge clk_sys);
        total++;
        if (proto_err !== 1'b0) begin
            bad++;
            $display("[TB] FAIL rnd_no_proto_err: got %b want 0", proto_err);
        end
    endtask

    task automatic test_invariants();
        total++;
        if (viol != 0) begin
            bad++;
            $display("[TB] FAIL invariants: got %0d violations want 0", viol);
        end
    endtask

    initial begin
        test_reset();
        test_download();
        test_upload();
        test_index_filter();
        test_proto_err();
        test_wrap();
        test_reset_mid();
        test_random();
        test_invariants();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #500000;
        $display("[TB] FAIL watchdog: simulation exceeded time limit");
        $fatal(1, "[TB] watchdog expired");
    end

endmodule
